// File: rtl/i2c_gain_regfile.sv
// I2C slave holding per-band equalizer gains: auto-increment shadow writes,
// active readback, and atomic shadow-to-active commit on an audio sample strobe.
module i2c_gain_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h6A,
  parameter int         NUM_BANDS  = 10,
  parameter logic [7:0] RESET_GAIN = 8'd16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scl,
  inout  wire                    sda,
  input  logic                   audio_valid,
  output logic [NUM_BANDS*8-1:0] gains,
  output logic                   gains_update,
  output logic                   commit_pending
);

  localparam int PTR_W = $clog2(NUM_BANDS);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK
  } state_t;

  state_t             state;
  logic [1:0]         scl_meta, sda_meta;
  logic               scl_d, sda_d;
  logic [3:0]         cnt;
  logic [6:0]         shift;
  logic [7:0]         tx;
  logic [PTR_W-1:0]   ptr;
  logic               rw;
  logic               sda_oe;
  logic               written;
  logic [7:0]         shadow [NUM_BANDS];
  logic [7:0]         active [NUM_BANDS];

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]       rx_byte;
  logic [PTR_W-1:0] ptr_next;

  // Idle bus is high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta <= 2'b11;
      sda_meta <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, exactly like hardware.
      scl_meta <= {scl_meta[0], scl};
      sda_meta <= {sda_meta[0], sda};
      scl_d    <= scl_meta[1];
      sda_d    <= sda_meta[1];
    end
  end

  assign scl_s     = scl_meta[1];
  assign sda_s     = sda_meta[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte   = {shift, sda_s};
  assign ptr_next  = (ptr == PTR_W'(NUM_BANDS - 1)) ? '0 : ptr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      shift   <= '0;
      tx      <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      written <= 1'b0;
      // NOTE: the shadow array is reset on purpose: its contents are visible
      // after the next commit, so it must hold a defined gain from power-up.
      for (int k = 0; k < NUM_BANDS; k++) shadow[k] <= RESET_GAIN;
    end else if (start_det) begin
      state  <= ST_ADDR;
      cnt    <= '0;
      sda_oe <= 1'b0;
    end else if (stop_det) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sda_oe  <= 1'b0;
      written <= 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shift <= rx_byte[6:0];
            cnt   <= cnt + 4'd1;
            rw    <= rx_byte[0];
            if (cnt == 4'd7 && rx_byte[7:1] != SLAVE_ADDR) state <= ST_IDLE;
          end else if (scl_fall && cnt == 4'd8) begin
            state  <= ST_ADDR_ACK;
            sda_oe <= 1'b1;
            cnt    <= '0;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              state  <= ST_RDATA;
              tx     <= active[ptr];
              sda_oe <= ~active[ptr][7];
            end else begin
              state  <= ST_PTR;
              sda_oe <= 1'b0;
            end
          end
        end
        ST_PTR: begin
          if (scl_rise) begin
            shift <= rx_byte[6:0];
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              if (int'(rx_byte) < NUM_BANDS) ptr <= rx_byte[PTR_W-1:0];
              else state <= ST_IDLE;
            end
          end else if (scl_fall && cnt == 4'd8) begin
            state  <= ST_PTR_ACK;
            sda_oe <= 1'b1;
            cnt    <= '0;
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state  <= ST_WDATA;
            sda_oe <= 1'b0;
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            shift <= rx_byte[6:0];
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              shadow[ptr] <= rx_byte;
              written     <= 1'b1;
              ptr         <= ptr_next;
            end
          end else if (scl_fall && cnt == 4'd8) begin
            state  <= ST_WDATA_ACK;
            sda_oe <= 1'b1;
            cnt    <= '0;
          end
        end
        ST_RDATA: begin
          // Count 0 on a falling edge only occurs after a master ACK: fetch the next byte.
          if (scl_rise) begin
            cnt <= cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              state  <= ST_RACK;
              sda_oe <= 1'b0;
              cnt    <= '0;
            end else if (cnt == 4'd0) begin
              tx     <= active[ptr];
              sda_oe <= ~active[ptr][7];
            end else begin
              tx     <= {tx[6:0], 1'b0};
              sda_oe <= ~tx[6];
            end
          end
        end
        ST_RACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr   <= ptr_next;
              state <= ST_RDATA;
              cnt   <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A STOP closing a write session arms the commit; it lands on a later strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gains_update   <= 1'b0;
      commit_pending <= 1'b0;
      for (int k = 0; k < NUM_BANDS; k++) active[k] <= RESET_GAIN;
    end else begin
      gains_update <= 1'b0;
      if (audio_valid && commit_pending) begin
        for (int k = 0; k < NUM_BANDS; k++) active[k] <= shadow[k];
        gains_update   <= 1'b1;
        commit_pending <= 1'b0;
      end
      if (stop_det && written) commit_pending <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_gains
    assign gains[8*k +: 8] = active[k];
  end

  assign sda = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_gain_regfile.sv
// Directed bench for i2c_gain_regfile: bit-banged I2C master, byte-level
// register model, per-cycle output comparison and hand-computed literals.
module tb_i2c_gain_regfile;

  localparam int NB = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  logic audio_valid = 1'b0;
  wire  sda_line;
  logic [NB*8-1:0] gains;
  logic gains_update, commit_pending;

  assign sda_line = m_low ? 1'b0 : 1'bz;
  pullup (sda_line);

  i2c_gain_regfile #(.SLAVE_ADDR(7'h6A), .NUM_BANDS(NB), .RESET_GAIN(8'd16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .scl            (scl),
    .sda            (sda_line),
    .audio_valid    (audio_valid),
    .gains          (gains),
    .gains_update   (gains_update),
    .commit_pending (commit_pending)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int upd_pulses = 0;

  logic [7:0] m_shadow [NB];
  logic [7:0] m_active [NB];
  int  m_ptr;
  bit  m_written, m_pending, m_update;
  bit  check_en = 1'b0;
  logic [7:0] wq [$];
  logic [7:0] rq [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NB*8-1:0] model_flat();
    logic [NB*8-1:0] f;
    for (int k = 0; k < NB; k++) f[8*k +: 8] = m_active[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NB; k++) begin
      m_shadow[k] = 8'd16;
      m_active[k] = 8'd16;
    end
    m_ptr = 0;
    m_written = 1'b0;
    m_pending = 1'b0;
    m_update = 1'b0;
  endtask

  always @(negedge clk) begin
    if (gains_update === 1'b1) upd_pulses++;
    if (check_en) begin
      check("gains", gains, model_flat());
      check("commit_pending", commit_pending, m_pending);
      check("gains_update", gains_update, m_update);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bus phases: SDA only moves mid-way through SCL low, 10 clk per half period.
  task automatic put_bit(input bit v);
    wait_clk(5); m_low = ~v;
    wait_clk(5); scl = 1'b1;
    wait_clk(10); scl = 1'b0;
  endtask

  task automatic get_bit(output bit v);
    wait_clk(5); m_low = 1'b0;
    wait_clk(5); scl = 1'b1;
    wait_clk(5); v = sda_line;
    wait_clk(5); scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(5); m_low = 1'b1;
    wait_clk(10); scl = 1'b0;
  endtask

  task automatic i2c_rep_start();
    wait_clk(5); m_low = 1'b0;
    wait_clk(5); scl = 1'b1;
    wait_clk(5); m_low = 1'b1;
    wait_clk(5); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    check_en = 1'b0;
    wait_clk(5); m_low = 1'b1;
    wait_clk(5); scl = 1'b1;
    wait_clk(5); m_low = 1'b0;
    wait_clk(8);
    if (m_written) begin
      m_pending = 1'b1;
      m_written = 1'b0;
    end
    check_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, input bit nack);
    bit v;
    for (int i = 7; i >= 0; i--) begin
      get_bit(v);
      b[i] = v;
    end
    put_bit(nack);
  endtask

  task automatic wr_txn(input logic [6:0] addr, input logic [7:0] ptrb, input bit do_stop,
                        input string tag);
    bit a, addr_ok, ptr_ok;
    i2c_start();
    addr_ok = (addr == 7'h6A);
    send_byte({addr, 1'b0}, a);
    check({tag, " addr_ack"}, a, !addr_ok);
    ptr_ok = addr_ok && (ptrb < NB);
    send_byte(ptrb, a);
    check({tag, " ptr_ack"}, a, !ptr_ok);
    if (ptr_ok) m_ptr = ptrb;
    foreach (wq[i]) begin
      send_byte(wq[i], a);
      check({tag, " data_ack"}, a, !ptr_ok);
      if (ptr_ok) begin
        m_shadow[m_ptr] = wq[i];
        m_written = 1'b1;
        m_ptr = (m_ptr + 1) % NB;
      end
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic rd_part(input int nbytes, input string tag);
    bit a;
    logic [7:0] b;
    rq = {};
    i2c_rep_start();
    send_byte({7'h6A, 1'b1}, a);
    check({tag, " read_addr_ack"}, a, 1'b0);
    for (int i = 0; i < nbytes; i++) begin
      recv_byte(b, i == nbytes - 1);
      check({tag, " read_data"}, b, m_active[m_ptr]);
      rq.push_back(b);
      if (i != nbytes - 1) m_ptr = (m_ptr + 1) % NB;
    end
    wait_clk(6);
    check({tag, " release_after_nack"}, sda_line, 1'b1);
  endtask

  task automatic pulse_audio();
    @(negedge clk); audio_valid = 1'b1;
    @(posedge clk); #1;
    audio_valid = 1'b0;
    if (m_pending) begin
      for (int k = 0; k < NB; k++) m_active[k] = m_shadow[k];
      m_update = 1'b1;
      m_pending = 1'b0;
    end
    wait_clk(1);
    m_update = 1'b0;
    wait_clk(3);
  endtask

  initial begin
    int p0;
    model_reset();
    wait_clk(3);
    check("reset gains", gains, {NB{8'd16}});
    check("reset pending", commit_pending, 1'b0);
    check("reset update", gains_update, 1'b0);
    check("reset sda", sda_line, 1'b1);
    rst_n = 1'b1;
    wait_clk(5);
    check_en = 1'b1;

    // Basic write of ten bytes from band 0, then commit.
    wq = {8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17};
    wr_txn(7'h6A, 8'h00, 1'b1, "basic");
    check("basic gains before commit", gains, {NB{8'd16}});
    check("basic pending", commit_pending, 1'b1);
    p0 = upd_pulses;
    pulse_audio();
    check("basic gains after commit", gains, {NB{8'd17}});
    check("basic pulse count", upd_pulses - p0, 1);
    check("basic pending cleared", commit_pending, 1'b0);

    // Strobe with nothing pending must not update.
    p0 = upd_pulses;
    pulse_audio();
    check("idle strobe pulses", upd_pulses - p0, 0);

    // Address mismatch: everything NACKed, nothing changes.
    wq = {8'h44};
    wr_txn(7'h55, 8'h01, 1'b1, "mismatch");
    check("mismatch pending", commit_pending, 1'b0);

    // Pointer wrap from band 8.
    wq = {8'd1, 8'd2, 8'd3};
    wr_txn(7'h6A, 8'h08, 1'b1, "wrap");
    pulse_audio();
    check("wrap gains", gains,
          {8'd2, 8'd1, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd3});

    // Readback of band 9 then wrapped band 0 through a repeated START.
    wq = {};
    wr_txn(7'h6A, 8'h09, 1'b0, "readback");
    rd_part(2, "readback");
    check("readback byte0", rq[0], 8'd2);
    check("readback byte1", rq[1], 8'd3);
    i2c_stop();
    check("readback pending", commit_pending, 1'b0);

    // Out-of-range pointer is NACKed and the rest ignored.
    wq = {8'h99};
    wr_txn(7'h6A, 8'h0A, 1'b1, "oor");
    check("oor pending", commit_pending, 1'b0);

    // Written flag survives a repeated START and arms commit at the final STOP.
    wq = {8'h33};
    wr_txn(7'h6A, 8'h03, 1'b0, "persist");
    rd_part(1, "persist");
    check("persist read band4", rq[0], 8'd17);
    check("persist pending before stop", commit_pending, 1'b0);
    i2c_stop();
    check("persist pending", commit_pending, 1'b1);
    pulse_audio();
    check("persist gains", gains,
          {8'd2, 8'd1, 8'd17, 8'd17, 8'd17, 8'd17, 8'h33, 8'd17, 8'd17, 8'd3});

    // Reset four bits into a data byte, after one completed byte.
    begin
      bit a;
      i2c_start();
      send_byte({7'h6A, 1'b0}, a);
      send_byte(8'h05, a);
      send_byte(8'hAA, a);
      check("midreset byte ack", a, 1'b0);
      put_bit(1'b0); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    end
    check_en = 1'b0;
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    check("midreset gains", gains, {NB{8'd16}});
    check("midreset pending", commit_pending, 1'b0);
    check("midreset update", gains_update, 1'b0);
    scl = 1'b1;
    m_low = 1'b0;
    model_reset();
    wait_clk(3);
    check("midreset sda", sda_line, 1'b1);
    rst_n = 1'b1;
    wait_clk(5);
    check_en = 1'b1;
    wq = {8'h42};
    wr_txn(7'h6A, 8'h02, 1'b1, "after_reset");
    check("after_reset pending", commit_pending, 1'b1);
    pulse_audio();
    check("after_reset gains", gains,
          {8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'h42, 8'd16, 8'd16});

    wait_clk(5);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
